// File: rtl/iobus_tty.sv
// Console teletype on the KA10 I/O bus: CONO/CONI/DATAO/DATAI decode, an async
// serial transmitter and receiver, and a PI request on the assigned channel.
module iobus_tty #(
    parameter logic [6:0] DEVCODE  = 7'o24,
    parameter int         BIT_CLKS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iobus_iob_reset,
    input  logic [3:9]  iobus_ios,
    input  logic        iobus_datao_clear,
    input  logic        iobus_datao_set,
    input  logic        iobus_cono_clear,
    input  logic        iobus_cono_set,
    input  logic        iobus_iob_datai,
    input  logic        iobus_iob_coni,
    input  logic [0:35] iobus_iob_out,
    output logic [0:35] iobus_iob_in,
    output logic [1:7]  iobus_pi,
    output logic        tx,
    input  logic        rx
);

    localparam int CW = $clog2(BIT_CLKS);

    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t tx_state, tx_state_next;
    rx_state_t rx_state, rx_state_next;

    logic          sel;
    logic          cono_clr, cono_set, dato_clr, dato_set;
    logic [2:0]    pia;
    logic          tto_busy, tto_flag, tti_busy, tti_flag;
    logic [7:0]    obuf, ibuf;
    logic          tx_go;
    logic [10:0]   tx_sh;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic          tx_tick, tx_load, tx_done;
    logic [1:0]    rx_sync;
    logic          rx_line, rx_prev, rx_fall;
    logic [7:0]    rx_sh;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic          rx_tick, rx_start, rx_false, rx_sample, rx_end, rx_stop_ok;
    logic          datai_d, datai_fall;
    logic          unused_bits;

    assign sel        = (iobus_ios == DEVCODE);
    assign cono_clr   = iobus_cono_clear  & sel;
    assign cono_set   = iobus_cono_set    & sel;
    assign dato_clr   = iobus_datao_clear & sel;
    assign dato_set   = iobus_datao_set   & sel;
    assign datai_fall = datai_d & ~iobus_iob_datai & sel;
    assign rx_line    = rx_sync[1];
    assign rx_fall    = rx_prev & ~rx_line;
    assign tx_tick    = (tx_cnt == CW'(BIT_CLKS - 1));
    assign rx_tick    = (rx_cnt == '0);
    assign unused_bits = ^iobus_iob_out[0:27];

    // Line is forced idle whenever the transmitter is not shifting, so any reset
    // releases it in the same cycle.
    assign tx = (tx_state == TX_SHIFT) ? tx_sh[0] : 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            rx_state <= RX_IDLE;
        end else if (iobus_iob_reset) begin
            tx_state <= TX_IDLE;
            rx_state <= RX_IDLE;
        end else begin
            tx_state <= tx_state_next;
            rx_state <= rx_state_next;
        end
    end

    // NOTE: every signal written here gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    always_comb begin
        tx_state_next = tx_state;
        tx_load       = 1'b0;
        tx_done       = 1'b0;
        case (tx_state)
            TX_IDLE:
                if (tx_go && !tto_busy) begin
                    tx_load       = 1'b1;
                    tx_state_next = TX_SHIFT;
                end
            TX_SHIFT:
                if (tx_tick && tx_bit == 4'd10) begin
                    tx_done       = 1'b1;
                    tx_state_next = TX_IDLE;
                end
        endcase
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_start      = 1'b0;
        rx_false      = 1'b0;
        rx_sample     = 1'b0;
        rx_end        = 1'b0;
        rx_stop_ok    = 1'b0;
        case (rx_state)
            RX_IDLE:
                if (rx_fall) begin
                    rx_start      = 1'b1;
                    rx_state_next = RX_START;
                end
            RX_START:
                if (rx_tick) begin
                    if (!rx_line) begin
                        rx_state_next = RX_DATA;
                    end else begin
                        rx_false      = 1'b1;
                        rx_state_next = RX_IDLE;
                    end
                end
            RX_DATA:
                if (rx_tick) begin
                    rx_sample = 1'b1;
                    if (rx_bit == 3'd7) rx_state_next = RX_STOP;
                end
            RX_STOP:
                if (rx_tick) begin
                    rx_end        = 1'b1;
                    rx_stop_ok    = rx_line;
                    rx_state_next = RX_IDLE;
                end
        endcase
    end

    // Frame is {stop, stop, data LSB-first, start}; shifting in 1s keeps the
    // tail at the stop level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_go  <= 1'b0;
            tx_sh  <= '1;
            tx_cnt <= '0;
            tx_bit <= '0;
        end else if (iobus_iob_reset) begin
            tx_go  <= 1'b0;
            tx_sh  <= '1;
            tx_cnt <= '0;
            tx_bit <= '0;
        end else begin
            tx_go <= dato_set;
            if (tx_load) begin
                tx_sh  <= {2'b11, obuf, 1'b0};
                tx_cnt <= '0;
                tx_bit <= '0;
            end else if (tx_state == TX_SHIFT) begin
                if (tx_tick) begin
                    tx_cnt <= '0;
                    tx_bit <= tx_bit + 4'd1;
                    tx_sh  <= {1'b1, tx_sh[10:1]};
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

    // The half-bit start delay puts every later sample in the middle of its bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
            rx_sh   <= '0;
            rx_cnt  <= '0;
            rx_bit  <= '0;
        end else if (iobus_iob_reset) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
            rx_sh   <= '0;
            rx_cnt  <= '0;
            rx_bit  <= '0;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_line;
            if (rx_start) begin
                rx_cnt <= CW'(BIT_CLKS / 2 - 1);
                rx_bit <= '0;
            end else if (rx_state != RX_IDLE) begin
                rx_cnt <= rx_tick ? CW'(BIT_CLKS - 1) : rx_cnt - 1'b1;
            end
            if (rx_sample) begin
                rx_sh  <= {rx_line, rx_sh[7:1]};
                rx_bit <= rx_bit + 3'd1;
            end
        end
    end

    // NOTE: obuf and ibuf are software-visible registers, not a memory array, so
    // they are cleared by both resets like any other state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pia      <= '0;
            tto_busy <= 1'b0;
            tto_flag <= 1'b0;
            tti_busy <= 1'b0;
            tti_flag <= 1'b0;
            obuf     <= '0;
            ibuf     <= '0;
            datai_d  <= 1'b0;
        end else if (iobus_iob_reset) begin
            pia      <= '0;
            tto_busy <= 1'b0;
            tto_flag <= 1'b0;
            tti_busy <= 1'b0;
            tti_flag <= 1'b0;
            obuf     <= '0;
            ibuf     <= '0;
            datai_d  <= 1'b0;
        end else begin
            datai_d <= iobus_iob_datai & sel;
            obuf    <= (dato_clr ? 8'h00 : obuf) | (dato_set ? iobus_iob_out[28:35] : 8'h00);

            if (cono_clr) pia <= '0;
            if (cono_set) pia <= iobus_iob_out[33:35];

            // Later assignments win: hardware events override CONO clears.
            if (cono_set && iobus_iob_out[29]) tti_busy <= 1'b0;
            if (rx_start)                      tti_busy <= 1'b1;
            if (rx_false || rx_end)            tti_busy <= 1'b0;

            if ((cono_set && iobus_iob_out[30]) || datai_fall) tti_flag <= 1'b0;
            if (rx_end && rx_stop_ok) begin
                tti_flag <= 1'b1;
                ibuf     <= rx_sh;
            end

            if (cono_set && iobus_iob_out[31]) tto_busy <= 1'b0;
            if (tx_load)                       tto_busy <= 1'b1;
            if (tx_done)                       tto_busy <= 1'b0;

            if (tx_load)                       tto_flag <= 1'b0;
            if (cono_set && iobus_iob_out[32]) tto_flag <= 1'b0;
            if (cono_set && iobus_iob_out[28]) tto_flag <= 1'b1;
            if (tx_done)                       tto_flag <= 1'b1;
        end
    end

    always_comb begin
        iobus_iob_in = '0;
        if (iobus_iob_coni && sel) begin
            iobus_iob_in[29]    = tti_busy;
            iobus_iob_in[30]    = tti_flag;
            iobus_iob_in[31]    = tto_busy;
            iobus_iob_in[32]    = tto_flag;
            iobus_iob_in[33:35] = pia;
        end
        if (iobus_iob_datai && sel) begin
            iobus_iob_in[28:35] = iobus_iob_in[28:35] | ibuf;
        end
    end

    always_comb begin
        iobus_pi = '0;
        for (int n = 1; n <= 7; n++) begin
            iobus_pi[n] = (pia == 3'(n)) && (tti_flag || tto_flag);
        end
    end

endmodule
